// File: rtl/uart_host_pkg.sv
// Shared state encoding and UART register map for the UART host sequencer.
// Imported by the sequencer top and its RX FIFO.
package uart_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CTRL_STB,
    CTRL_WAIT,
    RX_STB,
    RX_WAIT,
    TX_WR,
    GAP
  } SeqState;

  localparam logic [2:0] UART_ADDR_CTRL = 3'b000;
  localparam logic [2:0] UART_ADDR_RX   = 3'b001;
  localparam logic [2:0] UART_ADDR_TX   = 3'b010;

  localparam int CTRL_RX_AVAIL_BIT = 2;
  localparam int CTRL_TX_BUSY_BIT  = 1;

endpackage

// File: rtl/uart_host_sequencer_rx_fifo.sv
// Small RX byte FIFO between the UART read path and the CPU-side stream.
// A simultaneous pop frees the slot first, so a push into a full FIFO still lands.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  import uart_host_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_host_sequencer.sv
// Bus-side sequencer for UART_Component: polls Control, drains RX bytes into a FIFO
// and writes TX bytes when the transmitter is idle, with round-robin RX/TX polling.
module uart_host_sequencer #(
  parameter int RX_DEPTH = 4,
  parameter int TIMEOUT  = 255,
  parameter int POLL_GAP = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      uart_cs,
  output logic                      uart_rd_strobe,
  input  logic                      uart_rd_busy,
  output logic                      uart_wr,
  output logic [2:0]                uart_addr,
  output logic [7:0]                uart_wr_data,
  input  logic [7:0]                uart_rd_data,
  output logic [7:0]                rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  input  logic [7:0]                tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      rx_overflow,
  output logic                      timeout_err
);
  import uart_host_pkg::*;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  SeqState          state;
  SeqState          next_state;
  logic             intent_tx;
  logic             intent_tx_next;
  logic [TMO_W-1:0] tmo_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             busy_expired;
  logic             timeout_hit;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;

  assign busy_expired = uart_rd_busy && (tmo_cnt == TMO_LAST);
  assign rx_valid     = !fifo_empty;

  // intent_tx doubles as the round-robin memory: a TX-intent poll hands the next one to RX.
  always_comb begin
    next_state     = state;
    intent_tx_next = intent_tx;
    timeout_hit    = 1'b0;
    fifo_push      = 1'b0;
    case (state)
      IDLE: begin
        intent_tx_next = tx_valid && !intent_tx;
        next_state     = CTRL_STB;
      end
      CTRL_STB: next_state = CTRL_WAIT;
      CTRL_WAIT: begin
        if (busy_expired) begin
          timeout_hit = 1'b1;
          next_state  = GAP;
        end else if (!uart_rd_busy) begin
          if (uart_rd_data[CTRL_RX_AVAIL_BIT])
            next_state = RX_STB;
          else if (intent_tx && tx_valid && !uart_rd_data[CTRL_TX_BUSY_BIT])
            next_state = TX_WR;
          else
            next_state = GAP;
        end
      end
      RX_STB: next_state = RX_WAIT;
      RX_WAIT: begin
        if (busy_expired) begin
          timeout_hit = 1'b1;
          next_state  = GAP;
        end else if (!uart_rd_busy) begin
          fifo_push  = 1'b1;
          next_state = GAP;
        end
      end
      TX_WR: next_state = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      intent_tx   <= 1'b0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      rx_overflow <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state     <= next_state;
      intent_tx <= intent_tx_next;
      if (state == CTRL_STB || state == RX_STB)
        tmo_cnt <= '0;
      else if ((state == CTRL_WAIT || state == RX_WAIT) && uart_rd_busy)
        tmo_cnt <= tmo_cnt + 1'b1;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (timeout_hit) timeout_err <= 1'b1;
      if (fifo_push && fifo_full && !rx_ready) rx_overflow <= 1'b1;
    end
  end

  // Bus outputs are registered from next_state so they always line up with the state entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      uart_cs        <= 1'b1;
      uart_rd_strobe <= 1'b0;
      uart_wr        <= 1'b1;
      uart_addr      <= UART_ADDR_CTRL;
      uart_wr_data   <= '0;
      tx_ready       <= 1'b0;
    end else begin
      uart_cs        <= (next_state == IDLE) || (next_state == GAP);
      uart_rd_strobe <= (next_state == CTRL_STB) || (next_state == RX_STB);
      uart_wr        <= (next_state != TX_WR);
      tx_ready       <= (next_state == TX_WR);
      if (next_state == TX_WR) uart_wr_data <= tx_data;
      case (next_state)
        RX_STB, RX_WAIT: uart_addr <= UART_ADDR_RX;
        TX_WR:           uart_addr <= UART_ADDR_TX;
        default:         uart_addr <= UART_ADDR_CTRL;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH(RX_DEPTH)
  ) rx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(uart_rd_data),
    .pop      (rx_ready),
    .head_data(rx_data),
    .count    (rx_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
